// File: rtl/lsu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lsu_ctrl : RV32I load/store control ahead of a byte-addressed data memory  |
// | Rev 1.0  : initial release                                                 |
// +----------------------------------------------------------------------------+
module lsu_ctrl #(
  parameter int N = 32,
  localparam int AW = $clog2(N)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic          i_is_store,
  input  logic [2:0]    i_funct3,
  input  logic [31:0]   i_addr,
  input  logic [31:0]   i_st_data,
  output logic [31:0]   o_ld_data,
  output logic          o_done,
  output logic          o_err,
  output logic [AW-1:0] o_mem_addr,
  output logic [3:0]    o_mem_bmask,
  output logic [31:0]   o_mem_wdata,
  output logic          o_mem_wren,
  input  logic [31:0]   i_mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_DONE   = 2'b10
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_capture;
  logic          r_is_store;
  logic [2:0]    r_funct3;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_st_data;
  logic          r_err;
  logic [31:0]   r_ld_data;

  logic [2:0]    w_size;
  logic          w_bad_f3;
  logic          w_misalign;
  logic          w_out_of_range;
  logic          w_req_err;
  logic [3:0]    w_bmask;
  logic [31:0]   w_ld_ext;

  // Legality of the incoming request, judged before anything is registered
  always_comb begin
    case (i_funct3[1:0])
      2'b00:   w_size = 3'd1;
      2'b01:   w_size = 3'd2;
      default: w_size = 3'd4;
    endcase
  end

  assign w_bad_f3 = i_is_store ? (i_funct3[2] | (i_funct3[1:0] == 2'b11))
                               : ((i_funct3 == 3'b011) | (i_funct3[2:1] == 2'b11));
  assign w_misalign = ((i_funct3[1:0] == 2'b01) & i_addr[0]) |
                      ((i_funct3[1:0] == 2'b10) & (|i_addr[1:0]));
  assign w_out_of_range = ({1'b0, i_addr} + {30'd0, w_size}) > 33'(N);
  assign w_req_err = w_bad_f3 | w_misalign | w_out_of_range;

  always_comb begin
    case (r_funct3[1:0])
      2'b00:   w_bmask = 4'b0001;
      2'b01:   w_bmask = 4'b0011;
      default: w_bmask = 4'b1111;
    endcase
  end

  always_comb begin
    case (r_funct3)
      3'b000:  w_ld_ext = {{24{i_mem_rdata[7]}}, i_mem_rdata[7:0]};
      3'b100:  w_ld_ext = {24'd0, i_mem_rdata[7:0]};
      3'b001:  w_ld_ext = {{16{i_mem_rdata[15]}}, i_mem_rdata[15:0]};
      3'b101:  w_ld_ext = {16'd0, i_mem_rdata[15:0]};
      default: w_ld_ext = i_mem_rdata;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    o_ready     = 1'b0;
    o_done      = 1'b0;
    o_err       = 1'b0;
    o_mem_wren  = 1'b0;
    o_mem_bmask = 4'b0000;
    case (r_state)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = w_req_err ? S_DONE : S_ACCESS;
        end
      end
      S_ACCESS: begin
        o_mem_bmask = w_bmask;
        o_mem_wren  = r_is_store;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        o_done      = 1'b1;
        o_err       = r_err;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Load result is cleared at acceptance so stores and faults report zero
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_is_store <= 1'b0;
      r_funct3   <= 3'd0;
      r_addr     <= '0;
      r_st_data  <= 32'd0;
      r_err      <= 1'b0;
      r_ld_data  <= 32'd0;
    end else if (w_capture) begin
      r_is_store <= i_is_store;
      r_funct3   <= i_funct3;
      r_addr     <= i_addr[AW-1:0];
      r_st_data  <= i_st_data;
      r_err      <= w_req_err;
      r_ld_data  <= 32'd0;
    end else if ((r_state == S_ACCESS) && !r_is_store) begin
      r_ld_data  <= w_ld_ext;
    end
  end

  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_st_data;
  assign o_ld_data   = r_ld_data;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_lsu_ctrl : randomized bench for lsu_ctrl with a byte-level memory model |
// | Rev 1.0     : initial release                                              |
// +----------------------------------------------------------------------------+
module tb_lsu_ctrl;
  localparam int N  = 32;
  localparam int AW = $clog2(N);

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_valid = 1'b0;
  logic          i_is_store = 1'b0;
  logic [2:0]    i_funct3 = 3'd0;
  logic [31:0]   i_addr = 32'd0;
  logic [31:0]   i_st_data = 32'd0;
  logic          o_ready;
  logic [31:0]   o_ld_data;
  logic          o_done;
  logic          o_err;
  logic [AW-1:0] o_mem_addr;
  logic [3:0]    o_mem_bmask;
  logic [31:0]   o_mem_wdata;
  logic          o_mem_wren;
  logic [31:0]   mem_rdata;

  int total = 0;
  int bad   = 0;

  logic [7:0] dut_mem [N];
  logic [7:0] ref_mem [N];

  lsu_ctrl #(.N(N)) u_dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_is_store  (i_is_store),
    .i_funct3    (i_funct3),
    .i_addr      (i_addr),
    .i_st_data   (i_st_data),
    .o_ld_data   (o_ld_data),
    .o_done      (o_done),
    .o_err       (o_err),
    .o_mem_addr  (o_mem_addr),
    .o_mem_bmask (o_mem_bmask),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_wren  (o_mem_wren),
    .i_mem_rdata (mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  // Attached memory: lane k is byte o_mem_addr+k, cleared by the shared reset
  always @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int k = 0; k < N; k++) dut_mem[k] <= 8'h00;
    end else if (o_mem_wren) begin
      for (int k = 0; k < 4; k++)
        if (o_mem_bmask[k]) dut_mem[(int'(o_mem_addr) + k) % N] <= o_mem_wdata[8*k +: 8];
    end
  end

  always_comb begin
    mem_rdata = 32'd0;
    for (int k = 0; k < 4; k++) mem_rdata[8*k +: 8] = dut_mem[(int'(o_mem_addr) + k) % N];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int req_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit req_err(input bit st, input logic [2:0] f3, input logic [31:0] a);
    bit legal_f3;
    int sz;
    if (st) legal_f3 = (f3 inside {3'b000, 3'b001, 3'b010});
    else    legal_f3 = (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    sz = req_size(f3);
    if (!legal_f3) return 1'b1;
    if ((a % sz) != 0) return 1'b1;
    if (longint'(a) + longint'(sz) > longint'(N)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int a);
    longint v;
    int sz;
    v  = 0;
    sz = req_size(f3);
    for (int k = 0; k < sz; k++) v += longint'(ref_mem[a + k]) << (8 * k);
    if (!f3[2] && sz < 4 && v >= (longint'(1) << (8 * sz - 1))) v -= (longint'(1) << (8 * sz));
    return v[31:0];
  endfunction

  function automatic int mem_diffs();
    int n;
    n = 0;
    for (int k = 0; k < N; k++) if (dut_mem[k] !== ref_mem[k]) n++;
    return n;
  endfunction

  // Called at a falling edge; returns at the falling edge of the IDLE cycle after DONE
  task automatic do_req(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input bit hold);
    bit e;
    int sz;
    int waitc;
    logic [31:0] exp_ld;
    logic [3:0]  exp_bm;
    i_valid = 1'b1; i_is_store = st; i_funct3 = f3; i_addr = a; i_st_data = d;
    waitc = 0;
    while (!o_ready && waitc < 10) begin
      @(negedge i_clk);
      waitc++;
    end
    if (!o_ready) begin
      check("accept_timeout", 32'(o_ready), 32'd1);
      i_valid = 1'b0;
      return;
    end
    e  = req_err(st, f3, a);
    sz = req_size(f3);
    exp_bm = (sz == 1) ? 4'b0001 : (sz == 2) ? 4'b0011 : 4'b1111;
    @(posedge i_clk);
    #1;
    i_valid = hold; i_is_store = 1'($urandom); i_funct3 = 3'($urandom);
    i_addr = $urandom; i_st_data = $urandom;
    @(negedge i_clk);
    if (e) begin
      check("err_done", 32'(o_done), 32'd1);
      check("err_flag", 32'(o_err), 32'd1);
      check("err_wren", 32'(o_mem_wren), 32'd0);
      check("err_bmask", 32'(o_mem_bmask), 32'd0);
      check("err_lddata", o_ld_data, 32'd0);
      check("err_ready", 32'(o_ready), 32'd0);
    end else begin
      check("acc_done", 32'(o_done), 32'd0);
      check("acc_ready", 32'(o_ready), 32'd0);
      check("acc_wren", 32'(o_mem_wren), 32'(st));
      check("acc_bmask", 32'(o_mem_bmask), 32'(exp_bm));
      check("acc_addr", 32'(o_mem_addr), a % N);
      if (st) begin
        check("acc_wdata", o_mem_wdata, d);
        for (int k = 0; k < sz; k++) ref_mem[int'(a) + k] = d[8*k +: 8];
        exp_ld = 32'd0;
      end else begin
        exp_ld = ref_load(f3, int'(a));
      end
      @(negedge i_clk);
      check("done_pulse", 32'(o_done), 32'd1);
      check("done_err", 32'(o_err), 32'd0);
      check("done_lddata", o_ld_data, exp_ld);
      check("done_wren", 32'(o_mem_wren), 32'd0);
      check("done_bmask", 32'(o_mem_bmask), 32'd0);
    end
    @(negedge i_clk);
    check("after_done", 32'(o_done), 32'd0);
    check("after_ready", 32'(o_ready), 32'd1);
    check("mem_contents", 32'(mem_diffs()), 32'd0);
  endtask

  initial begin
    bit st;
    logic [2:0] f3;
    logic [31:0] a;
    logic [2:0] ld_ok [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int k = 0; k < N; k++) ref_mem[k] = 8'h00;

    repeat (3) @(negedge i_clk);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_wren", 32'(o_mem_wren), 32'd0);
    check("rst_lddata", o_ld_data, 32'd0);
    check("rst_bmask", 32'(o_mem_bmask), 32'd0);
    i_reset = 1'b1;
    @(negedge i_clk);
    check("idle_ready", 32'(o_ready), 32'd1);
    check("idle_done", 32'(o_done), 32'd0);

    do_req(1'b1, 3'b010, 32'd8, 32'h8000_00F1, 1'b0);
    do_req(1'b0, 3'b010, 32'd8, 32'd0, 1'b0);
    check("lw_value", o_ld_data, 32'h8000_00F1);
    do_req(1'b0, 3'b000, 32'd8, 32'd0, 1'b0);
    do_req(1'b0, 3'b100, 32'd8, 32'd0, 1'b0);
    do_req(1'b0, 3'b001, 32'd8, 32'd0, 1'b0);
    do_req(1'b0, 3'b101, 32'd8, 32'd0, 1'b0);
    do_req(1'b1, 3'b001, 32'd12, 32'h1234_8001, 1'b0);
    do_req(1'b0, 3'b001, 32'd12, 32'd0, 1'b0);
    check("lh_value", o_ld_data, 32'hFFFF_8001);

    do_req(1'b0, 3'b010, 32'd6, 32'd0, 1'b0);
    do_req(1'b1, 3'b001, 32'd3, 32'hAAAA_AAAA, 1'b0);
    do_req(1'b0, 3'b000, 32'(N), 32'd0, 1'b0);
    do_req(1'b1, 3'b010, 32'(N - 2), 32'h5555_5555, 1'b0);
    do_req(1'b0, 3'b010, 32'hFFFF_FFFC, 32'd0, 1'b0);

    do_req(1'b0, 3'b011, 32'd0, 32'd0, 1'b1);
    do_req(1'b1, 3'b000, 32'd5, 32'h0000_00A5, 1'b1);
    do_req(1'b1, 3'b100, 32'd0, 32'h1111_1111, 1'b1);
    do_req(1'b1, 3'b000, 32'd7, 32'h0000_005A, 1'b1);
    do_req(1'b0, 3'b110, 32'd0, 32'd0, 1'b1);
    do_req(1'b0, 3'b000, 32'd5, 32'd0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      st = 1'($urandom);
      if ($urandom_range(0, 4) == 0) f3 = 3'($urandom);
      else if (st) f3 = 3'($urandom_range(0, 2));
      else f3 = ld_ok[$urandom_range(0, 4)];
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else a = 32'($urandom_range(0, N + 3));
      do_req(st, f3, a, $urandom, 1'($urandom));
      if (!i_valid) repeat ($urandom_range(0, 2)) @(negedge i_clk);
    end
    i_valid = 1'b0;

    i_valid = 1'b1; i_is_store = 1'b1; i_funct3 = 3'b010; i_addr = 32'd0; i_st_data = 32'hDEAD_BEEF;
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    #2 i_reset = 1'b0;
    #1;
    check("abort_wren", 32'(o_mem_wren), 32'd0);
    check("abort_ready", 32'(o_ready), 32'd1);
    for (int k = 0; k < N; k++) ref_mem[k] = 8'h00;
    @(posedge i_clk);
    @(negedge i_clk);
    check("abort_nodone", 32'(o_done), 32'd0);
    i_reset = 1'b1;
    @(negedge i_clk);
    check("abort_nodone2", 32'(o_done), 32'd0);
    do_req(1'b0, 3'b010, 32'd0, 32'd0, 1'b0);
    check("abort_lw", o_ld_data, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store control stage directly upstream of the byte-addressed data memory in the RV32I core.
- Accepts one load or store request from the execute stage over a valid/ready handshake and checks alignment, range and funct3.
- Drives the memory's address, byte mask, write data and write enable.
- Captures and sign/zero-extends load data, then reports completion with a one-cycle done pulse.

Parameters:
N, 32, number of bytes in the attached memory (N is a power of 2, N >= 4); memory address width AW = $clog2(N)

Ports:
i_clk  input  1  clock, rising edge
i_reset  input  1  asynchronous active-low reset
i_valid  input  1  request valid from execute stage
o_ready  output  1  LSU can accept a request this cycle
i_is_store  input  1  1 = store, 0 = load
i_funct3  input  3  RV32I funct3 (LB/LH/LW/LBU/LHU = 000/001/010/100/101; SB/SH/SW = 000/001/010)
i_addr  input  32  effective byte address
i_st_data  input  32  store source register value
o_ld_data  output  32  extended load result, valid while o_done=1
o_done  output  1  one-cycle completion pulse
o_err  output  1  fault flag, valid while o_done=1
o_mem_addr  output  AW  memory byte address
o_mem_bmask  output  4  memory byte-lane enables
o_mem_wdata  output  32  memory write data
o_mem_wren  output  1  memory write enable
i_mem_rdata  input  32  memory combinational read data (byte 0 at o_mem_addr)

Behaviour:
- Reset (async, i_reset=0):
  - FSM returns to IDLE.
  - All request registers clear.
  - o_ready=1; o_done, o_err, o_mem_wren = 0; o_ld_data, o_mem_addr, o_mem_bmask, o_mem_wdata = 0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - o_ready=1.
  - On i_valid=1 at a rising edge, register is_store, funct3, addr and st_data.
  - Next state is ACCESS if the request is legal, otherwise DONE with err latched.
  - With i_valid=0, remain in IDLE.
- Legality (evaluated on the incoming request):
  - size = 1/2/4 for funct3[1:0] = 00/01/10.
  - Illegal funct3: load 011/110/111; store with funct3[2]=1 or funct3=011.
  - Misaligned: half with addr[0]=1; word with addr[1:0] != 00.
  - Out of range: addr + size > N, with the sum computed in 33 bits.
  - Any of these sets err. An erroneous request performs no memory access.
- ACCESS (exactly one cycle):
  - o_mem_addr = addr[AW-1:0].
  - o_mem_bmask = 0001 / 0011 / 1111 for byte / half / word.
  - o_mem_wdata = st_data unshifted, because the memory lane 0 maps to the addressed byte.
  - Store: o_mem_wren=1 for this cycle only, so the memory writes on the ACCESS→DONE edge.
  - Load: o_mem_wren=0; i_mem_rdata is extended and registered into o_ld_data on the ACCESS→DONE edge.
  - Extension rules:
    - LB: sign-extend rdata[7:0]. LBU: zero-extend rdata[7:0].
    - LH: sign-extend rdata[15:0]. LHU: zero-extend rdata[15:0].
    - LW: rdata as is.
  - Next state: DONE.
- DONE (exactly one cycle):
  - o_done=1; o_err = latched err.
  - o_ld_data holds the load result; it is 0 for stores and for errors.
  - o_ready=0. Next state: IDLE.
- Outside ACCESS: o_mem_wren=0 and o_mem_bmask=0000.
  - o_mem_addr and o_mem_wdata hold their last values; they carry no meaning.
- Latency (handshake at edge T):
  - Legal request: ACCESS in cycle T..T+1; o_done high in cycle T+1..T+2.
  - Error: o_done high in cycle T..T+1.
  - A new request is accepted no earlier than the edge ending DONE. Throughput is one request per 3 cycles (legal) or 2 cycles (error).
- i_valid while o_ready=0 is ignored; the requester holds it until accepted.
- Request inputs are sampled only at the handshake edge. Changes afterwards have no effect on the operation in flight.
- Reset mid-operation:
  - Asserted during ACCESS before the rising edge: the store is not committed, because wren drops asynchronously.
  - The attached memory shares i_reset and clears anyway.
  - No o_done is produced for the aborted request.

Test Plan:
- Reset while idle:
  - Stimulus: hold reset, then release.
  - Response: o_ready=1, o_done=0, o_mem_wren=0, o_ld_data=0.
- Word store then load:
  - Stimulus: SW addr=8, data=0x8000_00F1; then LW addr=8.
  - Response: store shows wren=1 with bmask=1111 for one cycle and o_done two cycles after handshake. Load returns o_ld_data=0x8000_00F1, o_err=0.
- Sign/zero extension:
  - Stimulus: after the word store above, issue LB 8, LBU 8, LH 8, LHU 8.
  - Response: 0xFFFF_FFF1, 0x0000_00F1, 0x0000_00F1, 0x0000_00F1.
  - Then SH addr=12 with data 0x1234_8001 followed by LH 12: result 0xFFFF_8001, and byte 14 is unchanged.
- Misalignment and range faults:
  - Stimulus: LW addr=6; SH addr=3; LB addr=N; SW addr=N-2.
  - Response: each gives o_done with o_err=1 one cycle after handshake, no wren pulse, and memory contents unchanged.
- Illegal funct3 and back-to-back:
  - Stimulus: load funct3=011, then store funct3=100; hold i_valid=1 continuously with alternating legal SB requests.
  - Response: o_err=1 for the illegal requests.
  - Each request is accepted only when o_ready=1, with exactly one o_done per accepted request.
- Reset mid-store:
  - Stimulus: SW addr=0, data=0xDEAD_BEEF; assert i_reset during ACCESS before the edge.
  - Response: no o_done; after release, LW addr=0 returns 0x0000_0000.
